// File: rtl/updown_counter_core.sv
// Loadable, enable-gated, modulo-2^WIDTH up/down counter.
// Priority per edge: reset > load > count > hold; count is a direct flop output.
module updown_counter_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             m,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next-state: load overrides counting; natural WIDTH-bit overflow gives the wrap.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = data_in;
    end else if (en) begin
      if (m) begin
        count_d = count_q + ONE;
      end else begin
        count_d = count_q - ONE;
      end
    end
  end

  // rst_n is active-high; the reset branch never looks at count_d, so unknown
  // inputs during reset cannot leak into the post-reset value.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_updown_counter_core.sv
// Self-checking bench for updown_counter_core: directed vector table followed
// by randomized stimulus checked against an integer-arithmetic reference model.
module tb_updown_counter_core;

  localparam int WIDTH = 8;
  localparam int MODV  = 1 << WIDTH;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             m;
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] count;

  int errors = 0;
  int checks = 0;

  updown_counter_core #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .m       (m),
    .load    (load),
    .data_in (data_in),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             rst;
    logic             en;
    logic             m;
    logic             load;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] exp;
    string            name;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic e, input logic md,
                              input logic ld, input logic [WIDTH-1:0] d,
                              input logic [WIDTH-1:0] x, input string nm);
    vec_t v;
    v.rst = r; v.en = e; v.m = md; v.load = ld; v.din = d; v.exp = x; v.name = nm;
    vecs.push_back(v);
  endfunction

  task automatic check(input string nm, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: count=%h expected=%h", nm, act, exp);
    end
  endtask

  // Drive on the falling edge, let the rising edge sample, check 1 time unit later.
  task automatic step(input logic r, input logic e, input logic md,
                      input logic ld, input logic [WIDTH-1:0] d);
    @(negedge clk);
    rst_n = r; en = e; m = md; load = ld; data_in = d;
    @(posedge clk);
    #1;
  endtask

  int model;
  int n_rst, n_ld;

  initial begin
    rst_n = 1'b1; en = 1'b0; m = 1'b0; load = 1'b0; data_in = '0;

    // reset with everything else active
    add(1, 1, 1, 1, 8'hA5, 8'h00, "reset_a");
    add(1, 1, 1, 1, 8'hA5, 8'h00, "reset_b");
    // count up then hold
    for (int i = 1; i <= 5; i++) add(0, 1, 1, 0, 8'h00, i[WIDTH-1:0], "count_up");
    for (int i = 0; i < 3; i++)  add(0, 0, 1, 0, 8'hFF, 8'h05, "hold");
    // load beats count, then mode switch takes effect immediately
    add(0, 1, 1, 1, 8'h3C, 8'h3C, "load_priority");
    add(0, 1, 0, 0, 8'h00, 8'h3B, "mode_down");
    add(0, 1, 1, 0, 8'h00, 8'h3C, "mode_up");
    // wrap up
    add(0, 0, 0, 1, 8'hFE, 8'hFE, "load_fe");
    add(0, 1, 1, 0, 8'h00, 8'hFF, "wrap_up_ff");
    add(0, 1, 1, 0, 8'h00, 8'h00, "wrap_up_00");
    add(0, 1, 1, 0, 8'h00, 8'h01, "wrap_up_01");
    // wrap down
    add(0, 0, 1, 1, 8'h01, 8'h01, "load_01");
    add(0, 1, 0, 0, 8'h00, 8'h00, "wrap_dn_00");
    add(0, 1, 0, 0, 8'h00, 8'hFF, "wrap_dn_ff");
    add(0, 1, 0, 0, 8'h00, 8'hFE, "wrap_dn_fe");
    // reset mid-count and resume
    add(0, 0, 0, 1, 8'h46, 8'h46, "load_46");
    add(0, 1, 1, 0, 8'h00, 8'h47, "up_47");
    add(1, 1, 1, 1, 8'h99, 8'h00, "mid_reset");
    add(0, 1, 1, 0, 8'h00, 8'h01, "resume");
    // load with en low, and max value load
    add(0, 0, 0, 1, 8'hFF, 8'hFF, "load_no_en");
    add(0, 0, 0, 0, 8'h12, 8'hFF, "hold_ff");

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].m, vecs[i].load, vecs[i].din);
      check($sformatf("%s[%0d]", vecs[i].name, i), count, vecs[i].exp);
    end

    // Randomized phase: model is a plain integer kept modulo 2^WIDTH.
    model = 'hFF;
    n_rst = 0;
    n_ld = 0;
    for (int c = 0; c < 3000; c++) begin
      logic r, e, md, ld;
      logic [WIDTH-1:0] d;
      r  = ($urandom_range(0, 19) == 0);
      ld = ($urandom_range(0, 7) == 0);
      e  = $urandom_range(0, 1);
      md = $urandom_range(0, 1);
      d  = $urandom_range(0, MODV - 1);
      step(r, e, md, ld, d);
      if (r) begin
        model = 0;
        n_rst++;
      end else if (ld) begin
        model = d;
        n_ld++;
      end else if (e) begin
        model = md ? (model + 1) % MODV : (model + MODV - 1) % MODV;
      end
      check($sformatf("random[%0d]", c), count, model[WIDTH-1:0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
